sort_unit_arbiter: RTL and testbench

- Shares one pipelined four-element sorting unit (fixed latency p_lat, no backpressure) between two requesters, A and B, each with its own val/rdy request and response interfaces.
- Performs round-robin arbitration on issue and tracks a requester tag alongside each in-flight sort.
- Steers each sorter result into a per-requester response buffer.
- Sits between the requester ports and the sorter's in/out ports; the sorter is instantiated outside this block.

---
 rtl/sort_unit_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sort_unit_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_unit_arbiter.sv
// sort_unit_arbiter: shares one fixed-latency four-element sorter between
// requesters A and B. It arbitrates round-robin on issue, carries a
// {valid, tag} pipe alongside the sorter so each result can be routed back,
// and holds the results in one small FIFO per requester. Each requester may
// only issue while it has credit, so the return path never overflows.
//
// Optional build macro: SORT_ARB_PERF_EN adds 16-bit grant counters on
// perf_grantsA/perf_grantsB. When it is undefined both ports are tied to 0.
//
// Priority pointer states:
//   PRIO_A | A wins when both requesters are eligible
//   PRIO_B | B wins when both requesters are eligible
module sort_unit_arbiter #(
  parameter int p_nbits = 8,
  parameter int p_lat   = 3,
  parameter int p_depth = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqA_val,
  output logic                 reqA_rdy,
  input  logic [4*p_nbits-1:0] reqA_msg,
  output logic                 respA_val,
  input  logic                 respA_rdy,
  output logic [4*p_nbits-1:0] respA_msg,
  input  logic                 reqB_val,
  output logic                 reqB_rdy,
  input  logic [4*p_nbits-1:0] reqB_msg,
  output logic                 respB_val,
  input  logic                 respB_rdy,
  output logic [4*p_nbits-1:0] respB_msg,
  output logic                 sort_in_val,
  output logic [4*p_nbits-1:0] sort_in_msg,
  input  logic                 sort_out_val,
  input  logic [4*p_nbits-1:0] sort_out_msg,
  output logic [15:0]          perf_grantsA,
  output logic [15:0]          perf_grantsB
);

  localparam int MW = 4 * p_nbits;
  localparam int AW = $clog2(p_depth);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(p_depth + p_lat + 1) + 1;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e            prio_q, prio_d;
  logic             active_q;
  logic [p_lat-1:0] tp_vld_q;
  logic [p_lat-1:0] tp_tag_q;
  logic [MW-1:0]    mem_q [2][p_depth];
  logic [AW-1:0]    wr_q  [2];
  logic [AW-1:0]    rd_q  [2];
  logic [OW-1:0]    occ_q [2];

  logic [CW-1:0]    inflight_a, inflight_b;
  logic             cred_a, cred_b, elig_a, elig_b;
  logic             grant_a, grant_b;
  logic             head_vld, head_tag;
  logic [1:0]       push, pop;

  // Credit, readiness, grant and issue; prio_d follows the grant.
  always_comb begin
    inflight_a = '0;
    inflight_b = '0;
    for (int i = 0; i < p_lat; i++) begin
      if (tp_vld_q[i]) begin
        if (tp_tag_q[i]) inflight_b = inflight_b + CW'(1);
        else             inflight_a = inflight_a + CW'(1);
      end
    end
    cred_a   = (CW'(occ_q[0]) + inflight_a) < CW'(p_depth);
    cred_b   = (CW'(occ_q[1]) + inflight_b) < CW'(p_depth);
    elig_a   = reqA_val && cred_a;
    elig_b   = reqB_val && cred_b;
    // ready deliberately ignores the requester's own val
    reqA_rdy = active_q && cred_a && !(elig_b && (prio_q == PRIO_B));
    reqB_rdy = active_q && cred_b && !(elig_a && (prio_q == PRIO_A));
    grant_a  = reqA_val && reqA_rdy;
    grant_b  = reqB_val && reqB_rdy;
    sort_in_val = grant_a || grant_b;
    sort_in_msg = '0;
    if (grant_a)      sort_in_msg = reqA_msg;
    else if (grant_b) sort_in_msg = reqB_msg;
    prio_d = prio_q;
    if (grant_a)      prio_d = PRIO_B;
    else if (grant_b) prio_d = PRIO_A;
  end

  // Priority pointer register; active_q keeps outputs quiet for one cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q   <= PRIO_A;
      active_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      active_q <= 1'b1;
    end
  end

  // Tag pipe shifts every cycle so its head lines up with the sorter output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp_vld_q <= '0;
      tp_tag_q <= '0;
    end else begin
      tp_vld_q[0] <= sort_in_val;
      tp_tag_q[0] <= grant_b;
      for (int i = 1; i < p_lat; i++) begin
        tp_vld_q[i] <= tp_vld_q[i-1];
        tp_tag_q[i] <= tp_tag_q[i-1];
      end
    end
  end

  assign head_vld  = tp_vld_q[p_lat-1];
  assign head_tag  = tp_tag_q[p_lat-1];
  assign push[0]   = head_vld && !head_tag;
  assign push[1]   = head_vld && head_tag;
  assign respA_val = active_q && (occ_q[0] != '0);
  assign respB_val = active_q && (occ_q[1] != '0);
  assign pop[0]    = respA_val && respA_rdy;
  assign pop[1]    = respB_val && respB_rdy;
  assign respA_msg = mem_q[0][rd_q[0]];
  assign respB_msg = mem_q[1][rd_q[1]];

  // Per-requester response FIFOs; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        wr_q[r]  <= '0;
        rd_q[r]  <= '0;
        occ_q[r] <= '0;
        for (int k = 0; k < p_depth; k++) mem_q[r][k] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) begin
          mem_q[r][wr_q[r]] <= sort_out_msg;
          wr_q[r]           <= wr_q[r] + AW'(1);
        end
        if (pop[r]) rd_q[r] <= rd_q[r] + AW'(1);
        if (push[r] && !pop[r])      occ_q[r] <= occ_q[r] + OW'(1);
        else if (!push[r] && pop[r]) occ_q[r] <= occ_q[r] - OW'(1);
      end
    end
  end

`ifdef SORT_ARB_PERF_EN
  logic [15:0] perf_a_q, perf_b_q;

  // Grant counters wrap naturally at 2^16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_a_q <= '0;
      perf_b_q <= '0;
    end else begin
      if (grant_a) perf_a_q <= perf_a_q + 16'd1;
      if (grant_b) perf_b_q <= perf_b_q + 16'd1;
    end
  end

  assign perf_grantsA = perf_a_q;
  assign perf_grantsB = perf_b_q;
`else
  assign perf_grantsA = '0;
  assign perf_grantsB = '0;
`endif

`ifndef SYNTHESIS
  localparam int FW = $clog2(p_lat + 1);
  logic [FW-1:0] flush_q;

  // Sorter outputs launched before a reset may still drain for p_lat cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               flush_q <= FW'(p_lat);
    else if (flush_q != '0)   flush_q <= flush_q - FW'(1);
  end

  // Sorter valid must track the tag pipe head once stale results have drained.
  always @(posedge clk) begin
    if (reset && (flush_q == '0)) assert (sort_out_val == head_vld);
  end
`endif

endmodule

// File: tb/tb_sort_unit_arbiter.sv
// Bench for sort_unit_arbiter: a behavioural 3-cycle sorter closes the loop,
// a negedge monitor scoreboards every issue and every response.
module tb_sort_unit_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA_val, reqA_rdy, respA_val, respA_rdy;
  logic        reqB_val, reqB_rdy, respB_val, respB_rdy;
  logic [31:0] reqA_msg, respA_msg, reqB_msg, respB_msg;
  logic        sort_in_val, sort_out_val;
  logic [31:0] sort_in_msg, sort_out_msg;
  logic [15:0] perf_grantsA, perf_grantsB;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] qA[$];
  logic [31:0] qB[$];
  bit          alt_en    = 0;
  bit          have_last = 0;
  bit          last_a    = 0;

  sort_unit_arbiter #(.p_nbits(8), .p_lat(LAT), .p_depth(2)) dut (
    .clk(clk), .reset(reset),
    .reqA_val(reqA_val), .reqA_rdy(reqA_rdy), .reqA_msg(reqA_msg),
    .respA_val(respA_val), .respA_rdy(respA_rdy), .respA_msg(respA_msg),
    .reqB_val(reqB_val), .reqB_rdy(reqB_rdy), .reqB_msg(reqB_msg),
    .respB_val(respB_val), .respB_rdy(respB_rdy), .respB_msg(respB_msg),
    .sort_in_val(sort_in_val), .sort_in_msg(sort_in_msg),
    .sort_out_val(sort_out_val), .sort_out_msg(sort_out_msg),
    .perf_grantsA(perf_grantsA), .perf_grantsB(perf_grantsB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sort4(input logic [31:0] m);
    logic [7:0] e [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) e[i] = m[8*i +: 8];
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3 - p; i++)
        if (e[i] > e[i+1]) begin
          t = e[i]; e[i] = e[i+1]; e[i+1] = t;
        end
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // Behavioural sorter, deliberately not reset so stale results survive a DUT reset.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    pm [LAT];
  initial for (int i = 0; i < LAT; i++) pm[i] = '0;
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], sort_in_val};
    pm[0] <= sort4(sort_in_msg);
    for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
  end
  assign sort_out_val = pv[LAT-1];
  assign sort_out_msg = pm[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for n edges and returns in the first cycle after release.
  task automatic do_reset(input int n);
    reset = 1'b0;
    reqA_val = 1'b0; reqB_val = 1'b0; respA_rdy = 1'b0; respB_rdy = 1'b0;
    reqA_msg = '0; reqB_msg = '0;
    @(negedge clk);
    chk("rst_reqA_rdy",  32'(reqA_rdy), 0);
    chk("rst_reqB_rdy",  32'(reqB_rdy), 0);
    chk("rst_respA_val", 32'(respA_val), 0);
    chk("rst_respB_val", 32'(respB_val), 0);
    chk("rst_sort_in",   {31'b0, sort_in_val} | sort_in_msg, 0);
    chk("rst_resp_msg",  respA_msg | respB_msg, 0);
    chk("rst_perf",      {perf_grantsA, perf_grantsB}, 0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Scoreboard monitor: push expected on grant, pop and compare on response.
  always @(negedge clk) begin
    logic gA, gB;
    if (!reset) begin
      qA.delete();
      qB.delete();
    end else begin
      gA = reqA_val && reqA_rdy;
      gB = reqB_val && reqB_rdy;
      if (gA || gB || sort_in_val) begin
        chk("issue_val", 32'(sort_in_val), 32'(gA || gB));
        chk("one_grant", 32'(gA && gB), 0);
      end
      if (gA) begin
        chk("issue_msgA", sort_in_msg, reqA_msg);
        qA.push_back(sort4(reqA_msg));
      end
      if (gB) begin
        chk("issue_msgB", sort_in_msg, reqB_msg);
        qB.push_back(sort4(reqB_msg));
      end
      if (alt_en && (gA || gB)) begin
        if (have_last) chk("alternate", 32'(gA), 32'(!last_a));
        last_a    = gA;
        have_last = 1;
      end
      if (respA_val && respA_rdy) begin
        if (qA.size() == 0) chk("ghost_respA", 1, 0);
        else                chk("respA", respA_msg, qA.pop_front());
      end
      if (respB_val && respB_rdy) begin
        if (qB.size() == 0) chk("ghost_respB", 1, 0);
        else                chk("respB", respB_msg, qB.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        gA, gB;
    int          lat, ai, bgr, na, nb;
    logic [31:0] a_msgs [3];
    logic [31:0] exp_pa, exp_pb;

    // reset state and the quiet first cycle after release
    do_reset(3);
    reqA_val = 1'b1; reqA_msg = 32'h01020304; respA_rdy = 1'b1; respB_rdy = 1'b1;
    @(negedge clk);
    chk("rdy_first_cycle",   32'(reqA_rdy), 0);
    chk("issue_first_cycle", 32'(sort_in_val), 0);
    tick();

    // single uncontended request: result and latency
    @(negedge clk);
    chk("T1_grant", 32'(reqA_rdy), 1);
    tick();
    reqA_val = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("T1_respB_idle", 32'(respB_val), 0);
      if (respA_val) begin
        lat = i;
        chk("T1_msg", respA_msg, 32'h04030201);
        break;
      end
      tick();
    end
    chk("T1_latency", lat, 4);
    repeat (6) tick();

    // full contention: strict alternation starting with A
    do_reset(3);
    respA_rdy = 1'b1; respB_rdy = 1'b1;
    reqA_val = 1'b1; reqB_val = 1'b1;
    reqA_msg = $urandom; reqB_msg = $urandom;
    have_last = 0; alt_en = 1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      gA = reqA_val && reqA_rdy;
      gB = reqB_val && reqB_rdy;
      if (c == 1) chk("T2_first_A", 32'(gA), 1);
      if (c >= 1 && c <= 4) chk("T2_back_to_back", 32'(sort_in_val), 1);
      tick();
      if (gA) reqA_msg = $urandom;
      if (gB) reqB_msg = $urandom;
    end
    alt_en = 0;
    reqA_val = 1'b0; reqB_val = 1'b0;
    repeat (8) tick();
    chk("T2_drainA", qA.size(), 0);
    chk("T2_drainB", qB.size(), 0);

    // A stalled by a full buffer while B keeps flowing
    do_reset(3);
    a_msgs[0] = 32'h10203040; a_msgs[1] = 32'hFF00807F; a_msgs[2] = 32'h05050101;
    respA_rdy = 1'b0; respB_rdy = 1'b1;
    reqA_val = 1'b1; reqA_msg = a_msgs[0];
    reqB_val = 1'b1; reqB_msg = $urandom;
    ai = 0; bgr = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      gA = reqA_val && reqA_rdy;
      gB = reqB_val && reqB_rdy;
      tick();
      if (gA) begin
        ai++;
        if (ai < 3) reqA_msg = a_msgs[ai];
      end
      if (gB) begin
        bgr++;
        reqB_msg = $urandom;
      end
    end
    @(negedge clk);
    chk("T3_A_grants", ai, 2);
    chk("T3_A_rdy_low", 32'(reqA_rdy), 0);
    chk("T3_B_progress", 32'(bgr >= 4), 1);
    chk("T3_respA_held", 32'(respA_val), 1);
    tick();

    // release A: still full this cycle, re-granted once a slot frees
    reqB_val = 1'b0;
    respA_rdy = 1'b1;
    @(negedge clk);
    chk("T4_rdy_while_full", 32'(reqA_rdy), 0);
    tick();
    @(negedge clk);
    chk("T4_regrant", 32'(reqA_rdy), 1);
    tick();
    reqA_val = 1'b0;
    repeat (10) tick();
    chk("T4_drainA", qA.size(), 0);
    chk("T4_drainB", qB.size(), 0);

    // reset with two sorts in flight: no ghost responses, priority back at A
    do_reset(3);
    respA_rdy = 1'b1; respB_rdy = 1'b1;
    reqA_val = 1'b1; reqB_val = 1'b1;
    reqA_msg = 32'h0A0B0C0D; reqB_msg = 32'h44332211;
    tick();
    @(negedge clk);
    chk("T5_grantA", 32'(reqA_rdy), 1);
    tick();
    @(negedge clk);
    chk("T5_grantB", 32'(reqB_rdy), 1);
    tick();
    do_reset(1);
    respA_rdy = 1'b1; respB_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("T5_no_ghostA", 32'(respA_val), 0);
      chk("T5_no_ghostB", 32'(respB_val), 0);
      tick();
    end
    reqA_val = 1'b1; reqB_val = 1'b1;
    reqA_msg = 32'h01010101; reqB_msg = 32'h02020202;
    @(negedge clk);
    chk("T5_prio_A", 32'(reqA_rdy), 1);
    chk("T5_prio_B_blocked", 32'(reqB_rdy), 0);
    tick();
    reqA_val = 1'b0; reqB_val = 1'b0;
    repeat (8) tick();
    chk("T5_drainA", qA.size(), 0);

    // grant counters: 5 to A, 3 to B
    do_reset(3);
    respA_rdy = 1'b1; respB_rdy = 1'b1;
    reqA_val = 1'b1; reqB_val = 1'b1;
    reqA_msg = $urandom; reqB_msg = $urandom;
    na = 0; nb = 0;
    for (int c = 0; c < 60 && (na < 5 || nb < 3); c++) begin
      @(negedge clk);
      gA = reqA_val && reqA_rdy;
      gB = reqB_val && reqB_rdy;
      tick();
      if (gA) begin
        na++;
        reqA_msg = $urandom;
        if (na == 5) reqA_val = 1'b0;
      end
      if (gB) begin
        nb++;
        reqB_msg = $urandom;
        if (nb == 3) reqB_val = 1'b0;
      end
    end
    reqA_val = 1'b0; reqB_val = 1'b0;
    chk("T6_grantsA_seen", na, 5);
    chk("T6_grantsB_seen", nb, 3);
    repeat (8) tick();
`ifdef SORT_ARB_PERF_EN
    exp_pa = 32'd5; exp_pb = 32'd3;
`else
    exp_pa = 32'd0; exp_pb = 32'd0;
`endif
    @(negedge clk);
    chk("T6_perfA", 32'(perf_grantsA), exp_pa);
    chk("T6_perfB", 32'(perf_grantsB), exp_pb);
    chk("T6_drainA", qA.size(), 0);
    chk("T6_drainB", qB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
